// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// Module      : half_adder
// Description : WIDTH independent half-adder lanes with combinational outputs
//               and a one-cycle registered copy on clk.
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic [WIDTH-1:0] sum_q,
   output logic [WIDTH-1:0] carry_q
);

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_carry;
   logic [WIDTH-1:0] r_sum_q;
   logic [WIDTH-1:0] r_carry_q;

   // Lanes share nothing, so an X on one lane stays on that lane.
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_lane
         assign w_sum[i]   = a[i] ^ b[i];
         assign w_carry[i] = a[i] & b[i];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum_q   <= '0;
         r_carry_q <= '0;
      end else begin
         r_sum_q   <= w_sum;
         r_carry_q <= w_carry;
      end
   end

   assign sum     = w_sum;
   assign carry   = w_carry;
   assign sum_q   = r_sum_q;
   assign carry_q = r_carry_q;

endmodule
`default_nettype wire

// File: tb/tb_half_adder.sv
`default_nettype none
// Testbench for half_adder: directed tests at WIDTH 1 and 4, then a randomized
// scoreboard run at WIDTH 8 against an arithmetic reference model.
module tb_half_adder;

   logic       clk = 1'b0;
   logic       clk_run = 1'b0;
   logic       rst = 1'b0;

   logic [0:0] a1 = '0, b1 = '0;
   logic [0:0] sum1, carry1, sum_q1, carry_q1;
   logic [3:0] a4 = '0, b4 = '0;
   logic [3:0] sum4, carry4, sum_q4, carry_q4;
   logic [7:0] a8 = '0, b8 = '0;
   logic [7:0] sum8, carry8, sum_q8, carry_q8;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] sb_q[$];

   half_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1),
      .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1)
   );
   half_adder #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4),
      .sum(sum4), .carry(carry4), .sum_q(sum_q4), .carry_q(carry_q4)
   );
   half_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8),
      .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   // Reference: add the two bits of each lane as integers; the low bit of the
   // lane total is the sum, the high bit is the carry. Returns {carry, sum}.
   function automatic logic [15:0] ref_add(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] s;
      logic [7:0] c;
      s = '0;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         int t;
         t = int'(x[i]) + int'(y[i]);
         s[i] = (t % 2) == 1;
         c[i] = (t / 2) == 1;
      end
      return {c, s};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Scoreboard monitor: the registered outputs are presented after each edge.
   always @(posedge clk) begin
      #2;
      if (sb_q.size() > 0) begin
         logic [15:0] e;
         e = sb_q.pop_front();
         chk("rand_sum_q", sum_q8, e[7:0]);
         chk("rand_carry_q", carry_q8, e[15:8]);
         chk("rand_q_exclusive", sum_q8 & carry_q8, 8'h00);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] e;
      logic [1:0]  ab;

      // Test 1: combinational truth table, clock stopped.
      for (int k = 0; k < 4; k++) begin
         ab = 2'(k);
         a1 = ab[1];
         b1 = ab[0];
         #10;
         e = ref_add({7'b0, a1}, {7'b0, b1});
         chk("comb1_sum", {7'b0, sum1}, e[7:0]);
         chk("comb1_carry", {7'b0, carry1}, e[15:8]);
      end

      // Test 2: reset held for two edges with both operands high.
      clk_run = 1'b1;
      rst = 1'b1;
      a1 = 1'b1;
      b1 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sum_q", {7'b0, sum_q1}, 8'h00);
      chk("rst_carry_q", {7'b0, carry_q1}, 8'h00);
      chk("rst_comb_carry", {7'b0, carry1}, 8'h01);

      // Test 3: one-cycle latency after reset release.
      @(negedge clk);
      rst = 1'b0;
      a1 = 1'b1;
      b1 = 1'b0;
      #1;
      chk("lat_before_sum_q", {7'b0, sum_q1}, 8'h00);
      @(posedge clk);
      #1;
      chk("lat_after_sum_q", {7'b0, sum_q1}, 8'h01);
      chk("lat_after_carry_q", {7'b0, carry_q1}, 8'h00);

      // Test 4: one-edge reset pulse mid-run.
      @(negedge clk);
      a1 = 1'b1;
      b1 = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_carry_q", {7'b0, carry_q1}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_resume_carry_q", {7'b0, carry_q1}, 8'h01);

      // Test 5: four lanes.
      @(negedge clk);
      a4 = 4'b1100;
      b4 = 4'b1010;
      #1;
      chk("w4_sum", {4'b0, sum4}, 8'b0000_0110);
      chk("w4_carry", {4'b0, carry4}, 8'b0000_1000);
      chk("w4_sum_q_before", {4'b0, sum_q4}, 8'h00);
      @(posedge clk);
      #1;
      chk("w4_sum_q", {4'b0, sum_q4}, 8'b0000_0110);
      chk("w4_carry_q", {4'b0, carry_q4}, 8'b0000_1000);

      // Test 6: randomized eight-lane run through the scoreboard.
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         e = ref_add(a8, b8);
         sb_q.push_back(e);
         #1;
         chk("rand_sum", sum8, e[7:0]);
         chk("rand_carry", carry8, e[15:8]);
         chk("rand_exclusive", sum8 & carry8, 8'h00);
      end
      repeat (3) @(posedge clk);
      #3;
      chk("sb_drained", 8'(sb_q.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
